// File: rtl/playfield_line_clear.sv
// Playfield line clear: scans the playfield from bottom to top. It drops every
// non-full row down over the full rows it removes, blanks the rows freed at the
// top, and reports how many rows were removed.
// Optional feature macro: LINE_CLEAR_QUEUE_EN. When it is defined, a start that
// arrives while busy is queued and runs right after the current pass.
module playfield_line_clear #(
    parameter int unsigned DIM_X = 10,  // tiles per row
    parameter int unsigned DIM_Y = 20   // rows; row 0 is top
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           lines_cleared,
    output logic [4:0]           rd_row,
    input  logic [DIM_X*3-1:0]   rd_data,
    output logic                 wr_en,
    output logic [4:0]           wr_row,
    output logic [DIM_X*3-1:0]   wr_data
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StEval,
        StFill,
        StDone
    } state_e;

    localparam logic [4:0] LastRow = 5'(DIM_Y - 1);

    state_e     state_q, state_d;
    logic [4:0] src_q, src_d;      // row being examined
    logic [4:0] dst_q, dst_d;      // next row to receive a surviving row
    logic [4:0] count_q, count_d;  // full rows found so far this pass
    logic       done_q, done_d;
    logic [4:0] lines_q, lines_d;
    logic       row_full;
`ifdef LINE_CLEAR_QUEUE_EN
    logic       pending_q, pending_d;
`endif

    // A row is full when no field holds the BLANK (zero) tile type.
    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < int'(DIM_X); c++) begin
            if (rd_data[3*c +: 3] == 3'b000) row_full = 1'b0;
        end
    end

    // Next-state logic and RAM-side outputs; RAM ports idle at zero outside their states.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        done_d  = 1'b0;
        lines_d = lines_q;
        rd_row  = '0;
        wr_en   = 1'b0;
        wr_row  = '0;
        wr_data = '0;
`ifdef LINE_CLEAR_QUEUE_EN
        pending_d = pending_q;
        if (state_q != StIdle && start) pending_d = 1'b1;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    src_d   = LastRow;
                    dst_d   = LastRow;
                    count_d = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                rd_row  = src_q;
                state_d = StEval;
            end
            StEval: begin
                if (row_full) begin
                    count_d = count_q + 5'd1;
                end else begin
                    // A row that is already in its final position needs no write.
                    if (dst_q != src_q) begin
                        wr_en   = 1'b1;
                        wr_row  = dst_q;
                        wr_data = rd_data;
                    end
                    dst_d = dst_q - 5'd1;
                end
                if (src_q != 5'd0) begin
                    src_d   = src_q - 5'd1;
                    state_d = StRead;
                end else begin
                    state_d = (count_d != 5'd0) ? StFill : StDone;
                end
            end
            StFill: begin
                wr_en  = 1'b1;
                wr_row = dst_q;
                dst_d  = dst_q - 5'd1;
                if (dst_q == 5'd0) state_d = StDone;
            end
            StDone: begin
                done_d  = 1'b1;
                lines_d = count_q;
                state_d = StIdle;
`ifdef LINE_CLEAR_QUEUE_EN
                if (pending_q || start) begin
                    pending_d = 1'b0;
                    src_d     = LastRow;
                    dst_d     = LastRow;
                    count_d   = '0;
                    state_d   = StRead;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            done_q  <= done_d;
            lines_q <= lines_d;
        end
    end

`ifdef LINE_CLEAR_QUEUE_EN
    // Queued start request.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) pending_q <= 1'b0;
        else        pending_q <= pending_d;
    end
`endif

    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign lines_cleared = lines_q;

endmodule

// File: tb/tb_playfield_line_clear.sv
// Directed self-checking bench for playfield_line_clear with a behavioural
// synchronous-read playfield RAM.
module tb_playfield_line_clear;

    localparam int W = 30;

    logic         clk = 1'b0;
    logic         rst_l;
    logic         start;
    logic         busy;
    logic         done;
    logic [4:0]   lines_cleared;
    logic [4:0]   rd_row;
    logic [W-1:0] rd_data;
    logic         wr_en;
    logic [4:0]   wr_row;
    logic [W-1:0] wr_data;

    logic [W-1:0] mem      [20];
    logic [W-1:0] init_mem [20];
    logic [W-1:0] exp_mem  [20];
    logic         load_req;
    int           wr_total = 0;
    int           bad_wr   = 0;
    int           n_cmp    = 0;
    int           n_bad    = 0;

    playfield_line_clear dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .lines_cleared(lines_cleared),
        .rd_row       (rd_row),
        .rd_data      (rd_data),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_data      (wr_data)
    );

    always #5 clk = ~clk;

    // Playfield RAM: synchronous read, bench-side bulk load.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 20; i++) mem[i] <= init_mem[i];
        end else if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
        rd_data <= mem[rd_row];
    end

    always @(posedge clk) begin
        if (wr_en) wr_total++;
        if (wr_en && !busy) bad_wr++;
    end

    function automatic logic [W-1:0] mk(input int c0, input int c1, input logic [2:0] t);
        logic [W-1:0] r = '0;
        for (int c = c0; c <= c1; c++) r[3*c +: 3] = t;
        return r;
    endfunction

    task automatic load_ram();
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after edge k0 until done is seen; raises start after edge kick_at.
    task automatic wait_done(input int kick_at, input int k0, output int done_at);
        int k = k0;
        done_at = -1;
        while (k < k0 + 150) begin
            @(posedge clk);
            k++;
            #1 start = (k == kick_at);
            if (done) begin
                done_at = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic set_one_line();
        for (int r = 0; r < 20; r++) begin
            init_mem[r] = '0;
            exp_mem[r]  = '0;
        end
        init_mem[19] = mk(0, 9, 3'd2);
        init_mem[18] = mk(3, 5, 3'd3);  // T base
        init_mem[17] = mk(0, 3, 3'd1);  // I bar
        exp_mem[19]  = mk(3, 5, 3'd3);
        exp_mem[18]  = mk(0, 3, 3'd1);
    endtask

    task automatic test_reset();
        #1;
        n_cmp += 7;
        if (busy !== 1'b0)          begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)          begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        if (wr_en !== 1'b0)         begin n_bad++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        if (lines_cleared !== 5'd0) begin n_bad++; $display("FAIL reset_lines got %0d want 0", lines_cleared); end
        if (rd_row !== 5'd0)        begin n_bad++; $display("FAIL reset_rd_row got %0d want 0", rd_row); end
        if (wr_row !== 5'd0)        begin n_bad++; $display("FAIL reset_wr_row got %0d want 0", wr_row); end
        if (wr_data !== '0)         begin n_bad++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        @(negedge clk) rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty();
        int d, w0;
        for (int r = 0; r < 20; r++) init_mem[r] = '0;
        load_ram();
        w0 = wr_total;
        pulse_start();
        wait_done(-1, 0, d);
        n_cmp += 4;
        if (d !== 41)               begin n_bad++; $display("FAIL empty_done_cycle got %0d want 41", d); end
        if (lines_cleared !== 5'd0) begin n_bad++; $display("FAIL empty_lines got %0d want 0", lines_cleared); end
        if (wr_total - w0 !== 0)    begin n_bad++; $display("FAIL empty_writes got %0d want 0", wr_total - w0); end
        if (busy !== 1'b0)          begin n_bad++; $display("FAIL empty_busy_at_done got %b want 0", busy); end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL empty_done_width got %b want 0", done); end
    endtask

    task automatic test_one_line();
        int d, w0;
        set_one_line();
        load_ram();
        w0 = wr_total;
        pulse_start();
        wait_done(-1, 0, d);
        n_cmp += 3;
        if (d !== 42)               begin n_bad++; $display("FAIL one_done_cycle got %0d want 42", d); end
        if (lines_cleared !== 5'd1) begin n_bad++; $display("FAIL one_lines got %0d want 1", lines_cleared); end
        if (wr_total - w0 !== 20)   begin n_bad++; $display("FAIL one_writes got %0d want 20", wr_total - w0); end
        for (int r = 0; r < 20; r++) begin
            n_cmp++;
            if (mem[r] !== exp_mem[r]) begin
                n_bad++;
                $display("FAIL one_row%0d got %h want %h", r, mem[r], exp_mem[r]);
            end
        end
    endtask

    task automatic test_four_lines();
        int d;
        for (int r = 0; r < 20; r++) begin
            init_mem[r] = '0;
            exp_mem[r]  = '0;
        end
        for (int r = 16; r < 20; r++) init_mem[r] = mk(0, 9, 3'(r - 12));
        init_mem[15] = mk(7, 7, 3'd5);
        exp_mem[19]  = mk(7, 7, 3'd5);
        load_ram();
        pulse_start();
        wait_done(-1, 0, d);
        n_cmp += 2;
        if (d !== 45)               begin n_bad++; $display("FAIL four_done_cycle got %0d want 45", d); end
        if (lines_cleared !== 5'd4) begin n_bad++; $display("FAIL four_lines got %0d want 4", lines_cleared); end
        for (int r = 0; r < 20; r++) begin
            n_cmp++;
            if (mem[r] !== exp_mem[r]) begin
                n_bad++;
                $display("FAIL four_row%0d got %h want %h", r, mem[r], exp_mem[r]);
            end
        end
    endtask

    task automatic test_full();
        int d, w0;
        for (int r = 0; r < 20; r++) init_mem[r] = mk(0, 9, 3'(1 + r % 7));
        load_ram();
        w0 = wr_total;
        pulse_start();
        wait_done(-1, 0, d);
        n_cmp += 3;
        if (d !== 61)                begin n_bad++; $display("FAIL full_done_cycle got %0d want 61", d); end
        if (lines_cleared !== 5'd20) begin n_bad++; $display("FAIL full_lines got %0d want 20", lines_cleared); end
        if (wr_total - w0 !== 20)    begin n_bad++; $display("FAIL full_writes got %0d want 20", wr_total - w0); end
        for (int r = 0; r < 20; r++) begin
            n_cmp++;
            if (mem[r] !== '0) begin n_bad++; $display("FAIL full_row%0d got %h want 0", r, mem[r]); end
        end
    endtask

    task automatic test_reset_mid_pass();
        int d;
        set_one_line();
        load_ram();
        pulse_start();
        repeat (10) @(posedge clk);
        #1 rst_l = 1'b0;
        #1;
        n_cmp += 6;
        if (busy !== 1'b0)          begin n_bad++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        if (done !== 1'b0)          begin n_bad++; $display("FAIL mid_reset_done got %b want 0", done); end
        if (wr_en !== 1'b0)         begin n_bad++; $display("FAIL mid_reset_wr_en got %b want 0", wr_en); end
        if (lines_cleared !== 5'd0) begin n_bad++; $display("FAIL mid_reset_lines got %0d want 0", lines_cleared); end
        if (rd_row !== 5'd0)        begin n_bad++; $display("FAIL mid_reset_rd_row got %0d want 0", rd_row); end
        if (wr_row !== 5'd0)        begin n_bad++; $display("FAIL mid_reset_wr_row got %0d want 0", wr_row); end
        @(negedge clk) rst_l = 1'b1;
        load_ram();
        pulse_start();
        wait_done(-1, 0, d);
        n_cmp += 2;
        if (d !== 42)               begin n_bad++; $display("FAIL rerun_done_cycle got %0d want 42", d); end
        if (lines_cleared !== 5'd1) begin n_bad++; $display("FAIL rerun_lines got %0d want 1", lines_cleared); end
        for (int r = 0; r < 20; r++) begin
            n_cmp++;
            if (mem[r] !== exp_mem[r]) begin
                n_bad++;
                $display("FAIL rerun_row%0d got %h want %h", r, mem[r], exp_mem[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, pulses;
        set_one_line();
        load_ram();
        pulse_start();
        wait_done(5, 0, d1);
        n_cmp++;
        if (d1 !== 42) begin n_bad++; $display("FAIL b2b_first_done got %0d want 42", d1); end
`ifdef LINE_CLEAR_QUEUE_EN
        // Second pass starts on the edge that leaves DONE and finds nothing full.
        wait_done(-1, d1, d2);
        n_cmp += 2;
        if (d2 !== 83)              begin n_bad++; $display("FAIL b2b_second_done got %0d want 83", d2); end
        if (lines_cleared !== 5'd0) begin n_bad++; $display("FAIL b2b_second_lines got %0d want 0", lines_cleared); end
`else
        d2 = 0;
        pulses = 0;
        repeat (60) begin
            @(posedge clk);
            #1 if (done) pulses++;
        end
        n_cmp += 2;
        if (pulses !== 0)  begin n_bad++; $display("FAIL b2b_ignored_start got %0d dones want 0", pulses); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_after got %b want 0", busy); end
`endif
        for (int r = 0; r < 20; r++) begin
            n_cmp++;
            if (mem[r] !== exp_mem[r]) begin
                n_bad++;
                $display("FAIL b2b_row%0d got %h want %h", r, mem[r], exp_mem[r]);
            end
        end
        n_cmp++;
        if (bad_wr !== 0) begin n_bad++; $display("FAIL write_while_idle got %0d want 0", bad_wr); end
    endtask

    initial begin
        rst_l    = 1'b0;
        start    = 1'b0;
        load_req = 1'b0;
        for (int r = 0; r < 20; r++) init_mem[r] = '0;
        test_reset();
        test_empty();
        test_one_line();
        test_four_lines();
        test_full();
        test_reset_mid_pass();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
